// File: rtl/sram_ctrl.sv
// Asynchronous 32-bit SRAM controller for the MEM stage: one access per request,
// with fixed SETUP / ACCESS(WAIT_CYCLES) / DONE timing and latched request fields.
`timescale 1ns/1ps
module sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req,
    input  logic [3:0]        sel,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              adel,
    input  logic              ades,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              stall,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [31:0]       sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        rdata_q, rdata_d;

    logic accept;
    logic active;
    logic is_wr;

    assign accept = (state_q == IDLE) && req && !adel && !ades;
    assign active = (state_q == SETUP) || (state_q == ACCESS);
    assign is_wr  = |sel_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = addr[ADDR_W+1:2];
                    wdata_d = wdata;
                    sel_d   = sel;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!is_wr) begin
                        rdata_d = sram_dq_i;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes decode straight from state so an asynchronous reset releases the bus at once.
    // Write data is driven through DONE to give the SRAM hold time after WE# rises.
    assign sram_addr  = addr_q;
    assign sram_dq_o  = wdata_q;
    assign sram_ce_n  = !active;
    assign sram_oe_n  = !(active && !is_wr);
    assign sram_we_n  = !((state_q == ACCESS) && is_wr);
    assign sram_dq_oe = (active || (state_q == DONE)) && is_wr;
    assign sram_be_n  = active ? (is_wr ? ~sel_q : 4'b0000) : 4'b1111;
    assign rdata      = rdata_q;
    assign ready      = (state_q == DONE);
    assign stall      = resetn && (accept || active);

    a_no_oe_we_overlap : assert property (@(posedge clk) disable iff (!resetn)
        !(!sram_we_n && !sram_oe_n));
    a_no_drive_while_read : assert property (@(posedge clk) disable iff (!resetn)
        !(sram_dq_oe && !sram_oe_n));

endmodule
